// File: rtl/pp_pkg.sv
// pp_pkg: shared types, widths and hop-record helpers for the Path Parser.
package pp_pkg;
    localparam int HOP_BASE          = 16;
    localparam int HOP_BYTES         = 4;
    localparam int HOP_IDX_NBITS     = 6;
    localparam int RCI_NBITS         = 8;
    localparam int PP_META_RCI_NBITS = 8;
    localparam int HOP_TYPE_NBITS    = 3;
    localparam int BP_NBITS          = 8;
    localparam int PATH_DATA_NBITS   = PP_META_RCI_NBITS + HOP_IDX_NBITS;
    localparam int HOP_INFO_NBITS    = HOP_TYPE_NBITS + RCI_NBITS + BP_NBITS;

    localparam logic [HOP_TYPE_NBITS-1:0] HOP_NULL               = 3'd0;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_START_PROCESS      = 3'd1;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_PROCESS            = 3'd2;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_END_PROCESS        = 3'd3;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_START_THREAD       = 3'd4;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_THREAD_PROCESS     = 3'd5;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_END_THREAD         = 3'd6;
    localparam logic [HOP_TYPE_NBITS-1:0] HOP_END_THREAD_PROCESS = 3'd7;

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DRAIN} state_t;

    typedef struct packed {
        logic [HOP_TYPE_NBITS-1:0] hop_type;
        logic [RCI_NBITS-1:0]      rci;
        logic [BP_NBITS-1:0]       byte_pointer;
    } hop_info_t;

    // Byte offset of a hop record, wrapped to the byte_pointer field width.
    function automatic logic [BP_NBITS-1:0] hop_byte_ptr(input logic [HOP_IDX_NBITS-1:0] idx);
        logic [31:0] v;
        v = HOP_BASE + 32'(idx) * HOP_BYTES;
        return v[BP_NBITS-1:0];
    endfunction
endpackage

// File: rtl/pp_hop_loader.sv
// pp_hop_loader: loads per-packet hop records into pp_sm's ping-pong hop FIFOs
// and pushes each packet's RCI into the meta FIFO.
module pp_hop_loader
    import pp_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         path_valid,
    input  logic                         path_sop,
    input  logic                         path_eop,
    input  logic [PATH_DATA_NBITS-1:0]   path_data,
    output logic                         path_ready,
    output logic                         hop_fifo_reset0,
    output logic                         hop_fifo_reset1,
    output logic                         hop_fifo_wr0,
    output logic                         hop_fifo_wr1,
    output logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata0,
    output logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata1,
    input  logic                         hop_fifo_full0,
    input  logic                         hop_fifo_full1,
    input  logic                         hop_fifo_fullm10,
    input  logic                         hop_fifo_fullm11,
    input  logic                         parse_done0,
    input  logic                         parse_done1,
    output logic                         pp_meta_valid,
    output logic [PP_META_RCI_NBITS-1:0] pp_meta_rci,
    output logic                         load_error
);
    state_t                         r_state, w_next;
    logic                           r_wptr;
    logic [1:0]                     r_busy;
    logic [PP_META_RCI_NBITS-1:0]   r_meta_rci;
    logic [HOP_IDX_NBITS-1:0]       r_cur_hop, r_hop_idx;
    logic                           r_wr_prev, r_sat_err;
    logic                           w_full, w_fullm1, w_done, w_in_pkt, w_abort, w_end;
    logic                           w_ready, w_acc, w_hop, w_keep, w_wr, w_sat, w_clear, w_hdr;
    logic [1:0]                     w_set;
    hop_info_t                      w_info;

    assign w_full   = r_wptr ? hop_fifo_full1 : hop_fifo_full0;
    assign w_fullm1 = r_wptr ? hop_fifo_fullm11 : hop_fifo_fullm10;
    assign w_done   = r_wptr ? parse_done1 : parse_done0;
    assign w_in_pkt = (r_state == LOAD) || (r_state == DRAIN);
    // A sop inside a packet closes it without being consumed; it is re-taken in IDLE.
    assign w_abort  = w_in_pkt & path_valid & path_sop;
    assign w_clear  = r_state == CLEAR;

    always_comb begin
        w_ready = 1'b0;
        w_next  = r_state;
        if (r_state == IDLE) begin
            w_ready = ~r_busy[r_wptr];
            w_next  = (path_valid & w_ready & path_sop) ? CLEAR : IDLE;
        end else if (r_state == CLEAR) begin
            w_next = LOAD;
        end else if (r_state == LOAD) begin
            w_ready = ~w_abort & ~w_full & ~(w_fullm1 & r_wr_prev);
            w_next  = (w_abort | (path_valid & w_ready & path_eop)) ? IDLE : w_done ? DRAIN : LOAD;
        end else begin
            w_ready = ~w_abort;
            w_next  = (w_abort | (path_valid & w_ready & path_eop)) ? IDLE : DRAIN;
        end
    end

    assign path_ready = w_ready & rst_n;
    assign w_acc      = path_valid & path_ready;
    assign w_hdr      = (r_state == IDLE) & w_acc & path_sop;
    assign w_hop      = w_in_pkt & w_acc;
    assign w_end      = w_in_pkt & (w_abort | (w_acc & path_eop));
    // Keep hop_idx >= cur_hop_idx-1; written as idx+1 >= cur so cur==0 keeps hop 0.
    assign w_keep     = ({1'b0, r_hop_idx} + 1'b1) >= {1'b0, r_cur_hop};
    assign w_wr       = w_hop & (r_state == LOAD) & w_keep;
    assign w_sat      = w_hop & (&r_hop_idx);
    assign w_set      = w_clear ? (r_wptr ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_info              = '0;
        w_info.hop_type     = path_data[RCI_NBITS +: HOP_TYPE_NBITS];
        w_info.rci          = path_data[RCI_NBITS-1:0];
        w_info.byte_pointer = hop_byte_ptr(r_hop_idx);
    end

    assign hop_fifo_reset0 = w_clear & ~r_wptr;
    assign hop_fifo_reset1 = w_clear & r_wptr;
    assign hop_fifo_wr0    = w_wr & ~r_wptr;
    assign hop_fifo_wr1    = w_wr & r_wptr;
    assign hop_fifo_wdata0 = hop_fifo_wr0 ? w_info : '0;
    assign hop_fifo_wdata1 = hop_fifo_wr1 ? w_info : '0;
    assign pp_meta_valid   = w_clear;
    assign pp_meta_rci     = r_meta_rci;
    assign load_error      = ((r_state == IDLE) & w_acc & ~path_sop) | w_abort | (w_sat & ~r_sat_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wptr     <= 1'b0;
            r_busy     <= 2'b00;
            r_meta_rci <= '0;
            r_cur_hop  <= '0;
            r_hop_idx  <= '0;
            r_wr_prev  <= 1'b0;
            r_sat_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wptr    <= r_wptr ^ w_end;
            r_busy    <= (r_busy & ~{parse_done1, parse_done0}) | w_set;
            r_wr_prev <= w_wr;
            if (w_hdr) begin
                r_meta_rci <= path_data[PATH_DATA_NBITS-1 -: PP_META_RCI_NBITS];
                r_cur_hop  <= path_data[HOP_IDX_NBITS-1:0];
                r_hop_idx  <= '0;
                r_sat_err  <= 1'b0;
            end else if (w_hop) begin
                r_hop_idx <= (&r_hop_idx) ? r_hop_idx : r_hop_idx + 1'b1;
                r_sat_err <= r_sat_err | w_sat;
            end
        end
    end

    // A buffer is only claimed once pp_sm has released it, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (rst_n)
            assert ((w_set & {parse_done1, parse_done0}) == 2'b00);
    end
endmodule

// File: tb/tb_pp_hop_loader.sv
// tb_pp_hop_loader: directed self-checking bench for pp_hop_loader.
module tb_pp_hop_loader;
    import pp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        path_valid = 1'b0, path_sop = 1'b0, path_eop = 1'b0;
    logic [13:0] path_data = '0;
    logic        path_ready;
    logic        hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1;
    logic [18:0] hop_fifo_wdata0, hop_fifo_wdata1;
    logic        hop_fifo_full0 = 1'b0, hop_fifo_full1 = 1'b0;
    logic        hop_fifo_fullm10 = 1'b0, hop_fifo_fullm11 = 1'b0;
    logic        parse_done0 = 1'b0, parse_done1 = 1'b0;
    logic        pp_meta_valid;
    logic [7:0]  pp_meta_rci;
    logic        load_error;

    int tests = 0, fails = 0;
    int rst0_cnt, rst1_cnt, meta_cnt, err_cnt, viol, snap_meta, snap_rst;
    logic        seen_wr0;
    logic [7:0]  last_meta;
    logic [18:0] q0[$], q1[$];

    always #5 clk = ~clk;

    pp_hop_loader dut (
        .clk(clk), .rst_n(rst_n),
        .path_valid(path_valid), .path_sop(path_sop), .path_eop(path_eop),
        .path_data(path_data), .path_ready(path_ready),
        .hop_fifo_reset0(hop_fifo_reset0), .hop_fifo_reset1(hop_fifo_reset1),
        .hop_fifo_wr0(hop_fifo_wr0), .hop_fifo_wr1(hop_fifo_wr1),
        .hop_fifo_wdata0(hop_fifo_wdata0), .hop_fifo_wdata1(hop_fifo_wdata1),
        .hop_fifo_full0(hop_fifo_full0), .hop_fifo_full1(hop_fifo_full1),
        .hop_fifo_fullm10(hop_fifo_fullm10), .hop_fifo_fullm11(hop_fifo_fullm11),
        .parse_done0(parse_done0), .parse_done1(parse_done1),
        .pp_meta_valid(pp_meta_valid), .pp_meta_rci(pp_meta_rci),
        .load_error(load_error)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (hop_fifo_wr0 && !seen_wr0) begin
                seen_wr0 = 1'b1;
                snap_meta = meta_cnt;
                snap_rst = rst0_cnt;
            end
            if (hop_fifo_wr0) q0.push_back(hop_fifo_wdata0);
            if (hop_fifo_wr1) q1.push_back(hop_fifo_wdata1);
            if (hop_fifo_wr0 && hop_fifo_full0) viol++;
            if (hop_fifo_reset0) rst0_cnt++;
            if (hop_fifo_reset1) rst1_cnt++;
            if (pp_meta_valid) begin
                meta_cnt++;
                last_meta = pp_meta_rci;
            end
            if (load_error) err_cnt++;
        end
    end

    function automatic logic [13:0] hop(input logic [2:0] t, input logic [7:0] r);
        return {3'b000, t, r};
    endfunction

    function automatic logic [13:0] hdr(input logic [7:0] r, input logic [5:0] c);
        return {r, c};
    endfunction

    function automatic logic [18:0] ew(input logic [2:0] t, input logic [7:0] r, input logic [7:0] bp);
        return {t, r, bp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        q0.delete();
        q1.delete();
        rst0_cnt = 0; rst1_cnt = 0; meta_cnt = 0; err_cnt = 0; viol = 0;
        seen_wr0 = 1'b0; snap_meta = 0; snap_rst = 0; last_meta = '0;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic sop, input logic eop, input logic [13:0] d);
        int n;
        n = 0;
        path_valid = 1'b1; path_sop = sop; path_eop = eop; path_data = d;
        @(negedge clk);
        while (!path_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!path_ready) chk("accept_timeout", 32'(path_ready), 32'd1);
        @(posedge clk);
        #1;
        path_valid = 1'b0; path_sop = 1'b0; path_eop = 1'b0; path_data = '0;
    endtask

    task automatic pkt(input logic [7:0] r, input int n);
        send(1'b1, 1'b0, hdr(r, 6'd0));
        for (int i = 0; i < n; i++)
            send(1'b0, i == n - 1, hop(HOP_PROCESS, r + 8'(i)));
    endtask

    task automatic pulse_done(input int b);
        if (b == 0) parse_done0 = 1'b1;
        else parse_done1 = 1'b1;
        @(posedge clk);
        #1;
        parse_done0 = 1'b0;
        parse_done1 = 1'b0;
    endtask

    initial begin
        clr();
        #12;
        chk("rst_ready", 32'(path_ready), 32'd0);
        chk("rst_meta_valid", 32'(pp_meta_valid), 32'd0);
        chk("rst_wr0", 32'(hop_fifo_wr0), 32'd0);
        chk("rst_reset0", 32'(hop_fifo_reset0), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(path_ready), 32'd1);
        @(posedge clk);
        #1;

        // cur_hop_idx=0, three hops into buffer 0
        clr();
        send(1'b1, 1'b0, hdr(8'hA1, 6'd0));
        send(1'b0, 1'b0, hop(HOP_START_PROCESS, 8'h10));
        send(1'b0, 1'b0, hop(HOP_PROCESS, 8'h11));
        send(1'b0, 1'b1, hop(HOP_END_PROCESS, 8'h12));
        chk("t1_wr0_count", 32'(q0.size()), 32'd3);
        chk("t1_hop0", 32'(q0[0]), 32'(ew(3'd1, 8'h10, 8'd16)));
        chk("t1_hop1", 32'(q0[1]), 32'(ew(3'd2, 8'h11, 8'd20)));
        chk("t1_hop2", 32'(q0[2]), 32'(ew(3'd3, 8'h12, 8'd24)));
        chk("t1_meta_count", 32'(meta_cnt), 32'd1);
        chk("t1_meta_rci", 32'(last_meta), 32'hA1);
        chk("t1_reset0_count", 32'(rst0_cnt), 32'd1);
        chk("t1_meta_before_wr", 32'(snap_meta), 32'd1);
        chk("t1_reset_before_wr", 32'(snap_rst), 32'd1);
        chk("t1_wr1_count", 32'(q1.size()), 32'd0);

        // cur_hop_idx=3, six hops: hops 0,1 dropped, land in buffer 1
        clr();
        send(1'b1, 1'b0, hdr(8'hB2, 6'd3));
        for (int i = 0; i < 6; i++)
            send(1'b0, i == 5, hop(HOP_THREAD_PROCESS, 8'h20 + 8'(i)));
        chk("t2_wr1_count", 32'(q1.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_hop%0d", k + 2), 32'(q1[k]),
                32'(ew(3'd5, 8'h22 + 8'(k), 8'(24 + 4 * k))));
        chk("t2_wr0_count", 32'(q0.size()), 32'd0);
        chk("t2_reset1_count", 32'(rst1_cnt), 32'd1);
        chk("t2_meta_rci", 32'(last_meta), 32'hB2);
        pulse_done(0);
        pulse_done(1);

        // back-to-back A,B then C stalls until buffer 0 is released
        clr();
        pkt(8'h40, 1);
        pkt(8'h50, 1);
        chk("t4_a_buf0", 32'(q0.size()), 32'd1);
        chk("t4_b_buf1", 32'(q1.size()), 32'd1);
        path_valid = 1'b1; path_sop = 1'b1; path_eop = 1'b0; path_data = hdr(8'h60, 6'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_c_stall", 32'(path_ready), 32'd0);
        end
        chk("t4_c_no_meta", 32'(meta_cnt), 32'd2);
        chk("t4_c_no_reset", 32'(rst0_cnt), 32'd1);
        pulse_done(0);
        send(1'b1, 1'b0, hdr(8'h60, 6'd0));
        send(1'b0, 1'b1, hop(HOP_PROCESS, 8'h61));
        chk("t4_c_reset0", 32'(rst0_cnt), 32'd2);
        chk("t4_c_meta", 32'(last_meta), 32'h60);
        chk("t4_c_hop", 32'(q0[1]), 32'(ew(3'd2, 8'h61, 8'd16)));
        pulse_done(1);
        pkt(8'h70, 1);
        pulse_done(0);
        pulse_done(1);

        // back-pressure on buffer 0
        clr();
        send(1'b1, 1'b0, hdr(8'hC3, 6'd0));
        send(1'b0, 1'b0, hop(HOP_PROCESS, 8'h30));
        hop_fifo_fullm10 = 1'b1;
        path_valid = 1'b1; path_data = hop(HOP_PROCESS, 8'h31);
        @(negedge clk);
        chk("t3_fullm1_after_wr", 32'(path_ready), 32'd0);
        send(1'b0, 1'b0, hop(HOP_PROCESS, 8'h31));
        hop_fifo_fullm10 = 1'b0;
        hop_fifo_full0 = 1'b1;
        path_valid = 1'b1; path_data = hop(HOP_PROCESS, 8'h32);
        repeat (5) begin
            @(negedge clk);
            chk("t3_full_stall", 32'(path_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        hop_fifo_full0 = 1'b0;
        send(1'b0, 1'b0, hop(HOP_PROCESS, 8'h32));
        send(1'b0, 1'b1, hop(HOP_PROCESS, 8'h33));
        chk("t3_wr0_count", 32'(q0.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_hop%0d", k), 32'(q0[k]),
                32'(ew(3'd2, 8'h30 + 8'(k), 8'(16 + 4 * k))));
        chk("t3_wr_while_full", 32'(viol), 32'd0);
        pulse_done(0);
        pkt(8'h80, 1);
        pulse_done(1);

        // parse_done0 after 2 of 8 hops: rest drained
        clr();
        send(1'b1, 1'b0, hdr(8'h90, 6'd0));
        send(1'b0, 1'b0, hop(HOP_PROCESS, 8'h91));
        send(1'b0, 1'b0, hop(HOP_PROCESS, 8'h92));
        pulse_done(0);
        for (int i = 0; i < 6; i++)
            send(1'b0, i == 5, hop(HOP_PROCESS, 8'h93 + 8'(i)));
        chk("t5_wr0_count", 32'(q0.size()), 32'd2);
        chk("t5_no_error", 32'(err_cnt), 32'd0);
        send(1'b1, 1'b0, hdr(8'hA5, 6'd0));
        send(1'b0, 1'b1, hop(HOP_START_THREAD, 8'hA6));
        chk("t5_next_reset1", 32'(rst1_cnt), 32'd1);
        chk("t5_next_hop", 32'(q1[0]), 32'(ew(3'd4, 8'hA6, 8'd16)));
        chk("t5_wr0_after", 32'(q0.size()), 32'd2);

        // stray hop beat in IDLE
        clr();
        path_valid = 1'b1; path_sop = 1'b0; path_eop = 1'b0; path_data = hop(HOP_START_PROCESS, 8'h01);
        @(negedge clk);
        chk("t6_ready", 32'(path_ready), 32'd1);
        chk("t6_load_error", 32'(load_error), 32'd1);
        @(posedge clk);
        #1;
        path_valid = 1'b0; path_data = '0;
        @(negedge clk);
        chk("t6_error_pulse_end", 32'(load_error), 32'd0);
        chk("t6_error_count", 32'(err_cnt), 32'd1);
        chk("t6_no_writes", 32'(q0.size() + q1.size()), 32'd0);
        chk("t6_no_meta", 32'(meta_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
